// File: rtl/instr_enc_if.sv
// Request/response bundle for the instruction encoder: field request in, packed words out.
// Carries no logic; the encoder owns all timing.
// The request side stalls on in_ready; the word side stalls on out_ready.
interface instr_enc_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    fmt;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [2:0]    funct3;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rs3;
    logic [1:0]    set_type;
    logic [6:0]    funct7;
    logic [11:0]   imm12;
    logic [12:0]   branch_off;
    logic [4:0]    round_start;
    logic [4:0]    rep;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [LW-1:0] fifo_level;
    logic          busy;
    logic          err_illegal;

    modport slave (
        input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, rs3, set_type,
               funct7, imm12, branch_off, round_start, rep, out_ready,
        output in_ready, out_valid, out_instr, fifo_level, busy, err_illegal
    );

    modport master (
        output in_valid, fmt, opcode, rd, funct3, rs1, rs2, rs3, set_type,
               funct7, imm12, branch_off, round_start, rep, out_ready,
        input  in_ready, out_valid, out_instr, fifo_level, busy, err_illegal
    );
endinterface

// File: rtl/instr_enc.sv
// Packs instruction fields into 32-bit words; RND requests expand into rep+1 words with rising round.
// Latency: first word visible 1 cycle after accept; repeat words follow one per non-full cycle.
// Backpressure: in_ready low while expanding or FIFO full; expansion holds (no skip) while full.
// Optional build macro INSTR_ENC_STRICT_EN: also reject opcode[1:0]!=2'b11 and odd branch offsets.

module instr_enc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push_vld,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop_rdy,
    output logic                       o_pop_vld,
    output logic [W-1:0]               o_pop_dat,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Full/empty come from the registered count, so a pop never frees a slot for a same-cycle push.
    assign o_full    = (r_count == LW'(DEPTH));
    assign o_pop_vld = (r_count != '0);
    assign o_pop_dat = o_pop_vld ? r_mem[r_rptr] : '0;
    assign o_level   = r_count;
    assign w_push    = i_push_vld && !o_full;
    assign w_pop     = o_pop_vld && i_pop_rdy;

    // Storage write; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + LW'(1);
            else if (w_pop && !w_push) r_count <= r_count - LW'(1);
        end
    end
endmodule

module instr_enc #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    instr_enc_if.slave  bus
);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_base;
    logic [4:0]    r_round;
    logic [4:0]    r_remain;
    logic          r_err;
    logic [31:0]   w_word;
    logic          w_reject;
    logic          w_accept;
    logic          w_full;
    logic          w_push;
    logic [31:0]   w_push_dat;
    logic          w_load;
    logic          w_step;
    logic [LW-1:0] w_level;

    // Field packing, one bit layout per format; the decoder extracts the same positions.
    always_comb begin
        w_word = 32'h0;
        case (bus.fmt)
            3'd0: w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd1: w_word = {bus.imm12, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd2: w_word = {bus.imm12[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm12[4:0], bus.opcode};
            3'd3: w_word = {bus.branch_off[12], bus.branch_off[10:5], bus.rs2, bus.rs1, bus.funct3,
                            bus.branch_off[4:1], bus.branch_off[11], bus.opcode};
            3'd4: w_word = {bus.set_type, bus.rs3, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd5: w_word = {bus.funct7, bus.round_start, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            default: w_word = 32'h0;
        endcase
    end

`ifdef INSTR_ENC_STRICT_EN
    assign w_reject = (bus.fmt[2] && bus.fmt[1]) || (bus.opcode[1:0] != 2'b11) ||
                      ((bus.fmt == 3'd3) && bus.branch_off[0]);
`else
    // Offset bit 0 is implied zero for branches and is simply dropped.
    logic w_unused_bits;
    assign w_unused_bits = bus.branch_off[0];
    assign w_reject      = bus.fmt[2] && bus.fmt[1];
`endif

    assign bus.in_ready = (r_state == S_IDLE) && !w_full;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Next-state and push selection: instance 0 at accept, repeat instances while EMIT and not full.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_dat  = w_word;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_reject) begin
                    w_push = 1'b1;
                    if ((bus.fmt == 3'd5) && (bus.rep != 5'd0)) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                w_push_dat = {r_base[31:25], r_round, r_base[19:0]};
                if (!w_full) begin
                    w_push = 1'b1;
                    w_step = 1'b1;
                    if (r_remain == 5'd1) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Repeat engine: latched template, next round value (5-bit wrap) and instances still owed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base   <= 32'h0;
            r_round  <= 5'd0;
            r_remain <= 5'd0;
        end else if (w_load) begin
            r_base   <= w_word;
            r_round  <= bus.round_start + 5'd1;
            r_remain <= bus.rep;
        end else if (w_step) begin
            r_round  <= r_round + 5'd1;
            r_remain <= r_remain - 5'd1;
        end
    end

    // A rejected request still completes its handshake; flag it for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= w_accept && w_reject;
    end

    instr_enc_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push_vld (w_push),
        .i_push_dat (w_push_dat),
        .i_pop_rdy  (bus.out_ready),
        .o_pop_vld  (bus.out_valid),
        .o_pop_dat  (bus.out_instr),
        .o_full     (w_full),
        .o_level    (w_level)
    );

    assign bus.fifo_level  = w_level;
    assign bus.busy        = (r_state == S_EMIT);
    assign bus.err_illegal = r_err;
endmodule

// File: tb/tb_instr_enc.sv
module tb_instr_enc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_enc_if #(.DEPTH(4)) bus ();
    instr_enc #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [1:0]  st;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [12:0] off;
        logic [4:0]  rstart;
        logic [4:0]  rep;
    } req_t;

    int pass_cnt = 0;
    int total_cnt = 0;
    int pops = 0;
    logic [31:0] exp_q[$];
    logic err_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference encoding built from shifted fields, independent of any concatenation layout.
    function automatic logic [31:0] model_enc(input req_t r, input int unsigned round);
        int unsigned w;
        int unsigned off;
        off = 32'(r.off);
        w = 32'(r.op) | (32'(r.f3) << 12) | (32'(r.rs1) << 15);
        case (r.fmt)
            3'd0: w |= (32'(r.rd) << 7) | (32'(r.rs2) << 20) | (32'(r.f7) << 25);
            3'd1: w |= (32'(r.rd) << 7) | (32'(r.imm) << 20);
            3'd2: w |= ((32'(r.imm) & 31) << 7) | (32'(r.rs2) << 20) | ((32'(r.imm) >> 5) << 25);
            3'd3: w |= (((off >> 11) & 1) << 7) | (((off >> 1) & 15) << 8) | (32'(r.rs2) << 20)
                     | (((off >> 5) & 63) << 25) | (((off >> 12) & 1) << 31);
            3'd4: w |= (32'(r.rd) << 7) | (32'(r.rs2) << 20) | (32'(r.rs3) << 25) | (32'(r.st) << 30);
            3'd5: w |= (32'(r.rd) << 7) | ((round % 32) << 20) | (32'(r.f7) << 25);
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic bit model_reject(input req_t r);
        bit rej;
        rej = (r.fmt >= 6);
`ifdef INSTR_ENC_STRICT_EN
        if ((r.op % 4) != 3) rej = 1;
        if (r.fmt == 3 && (r.off % 2) == 1) rej = 1;
`endif
        return rej;
    endfunction

    function automatic req_t cur_req();
        req_t r;
        r.fmt = bus.fmt; r.op = bus.opcode; r.rd = bus.rd; r.f3 = bus.funct3;
        r.rs1 = bus.rs1; r.rs2 = bus.rs2; r.rs3 = bus.rs3; r.st = bus.set_type;
        r.f7 = bus.funct7; r.imm = bus.imm12; r.off = bus.branch_off;
        r.rstart = bus.round_start; r.rep = bus.rep;
        return r;
    endfunction

    // Compare process: handshakes are stable at the falling edge and take effect at the next rising edge.
    always @(negedge clk) begin
        req_t r;
        bit acc;
        if (reset) begin
            exp_q.delete();
            err_pend = 1'b0;
        end else begin
            if (err_pend || bus.err_illegal) check("err_pulse", 32'(bus.err_illegal), 32'(err_pend));
            if (bus.out_valid && exp_q.size() == 0) check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                check("fifo_order", bus.out_instr, exp_q[0]);
                void'(exp_q.pop_front());
                pops++;
            end
            r = cur_req();
            acc = bus.in_valid && bus.in_ready;
            err_pend = acc && model_reject(r);
            if (acc && !model_reject(r)) begin
                if (r.fmt == 3'd5) begin
                    for (int i = 0; i <= int'(r.rep); i++) exp_q.push_back(model_enc(r, 32'(r.rstart) + i));
                end else begin
                    exp_q.push_back(model_enc(r, 0));
                end
            end
        end
    end

    task automatic drive(input req_t r);
        bus.fmt = r.fmt; bus.opcode = r.op; bus.rd = r.rd; bus.funct3 = r.f3;
        bus.rs1 = r.rs1; bus.rs2 = r.rs2; bus.rs3 = r.rs3; bus.set_type = r.st;
        bus.funct7 = r.f7; bus.imm12 = r.imm; bus.branch_off = r.off;
        bus.round_start = r.rstart; bus.rep = r.rep;
    endtask

    // Call just after a rising edge; returns just after the edge that accepted the request.
    task automatic send(input req_t r);
        int n;
        drive(r);
        bus.in_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic req_t zero_req();
        req_t r;
        r = '{default: '0};
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.fmt = 3'($urandom_range(0, 7));
        r.op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : {5'($urandom), 2'b11};
        r.rd = 5'($urandom); r.f3 = 3'($urandom); r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom); r.rs3 = 5'($urandom); r.st = 2'($urandom);
        r.f7 = 7'($urandom); r.imm = 12'($urandom); r.off = 13'($urandom);
        r.rstart = 5'($urandom); r.rep = 5'($urandom_range(0, 6));
        return r;
    endfunction

    logic [31:0] rnd_exp [4];
    bit rand_done;

    initial begin
        req_t r;
        int cnt;
        int p0;
        rnd_exp = '{32'h01E0000B, 32'h01F0000B, 32'h0000000B, 32'h0010000B};
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive(zero_req());

        // Reset values
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_level", 32'(bus.fifo_level), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err_illegal), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // R example: word visible one cycle after accept
        @(posedge clk); #1;
        r = zero_req();
        r.fmt = 0; r.op = 7'h33; r.rd = 5; r.rs1 = 6; r.rs2 = 7; r.f7 = 7'h20;
        check("model_r", model_enc(r, 0), 32'h407302B3);
        send(r);
        @(negedge clk);
        check("r_out_valid", 32'(bus.out_valid), 32'd1);
        check("r_word", bus.out_instr, 32'h407302B3);
        check("r_level", 32'(bus.fifo_level), 32'd1);
        drain();

        // B example with negative offset
        r = zero_req();
        r.fmt = 3; r.op = 7'h63; r.rs1 = 1; r.rs2 = 2; r.f3 = 1; r.off = 13'h1FF8;
        check("model_b", model_enc(r, 0), 32'hFE209CE3);
        send(r);
        @(negedge clk);
        check("b_word", bus.out_instr, 32'hFE209CE3);
        drain();

        // RND repeat with round wrap
        bus.out_ready = 1'b0;
        r = zero_req();
        r.fmt = 5; r.op = 7'h0B; r.rstart = 30; r.rep = 3;
        send(r);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.busy) cnt++;
        end
        check("rnd_busy_cycles", 32'(cnt), 32'd3);
        check("rnd_level", 32'(bus.fifo_level), 32'd4);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rnd_word", bus.out_instr, rnd_exp[i]);
        end
        drain();

        // Backpressure: fifth request waits until the consumer releases
        bus.out_ready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            r = zero_req();
            r.fmt = 0; r.op = 7'h33; r.rd = 5'(i + 1); r.rs1 = 5'(i);
            send(r);
        end
        r.rd = 5'd31;
        fork
            send(r);
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                check("bp_level", 32'(bus.fifo_level), 32'd4);
                @(posedge clk); #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_pop_count", 32'(pops - p0), 32'd5);

        // Illegal format: handshake completes, nothing stored, single error pulse
        bus.out_ready = 1'b0;
        r = zero_req();
        r.fmt = 1; r.op = 7'h13; r.imm = 12'hABC;
        send(r);
        r.fmt = 7;
        send(r);
        @(negedge clk);
        check("ill_err_hi", 32'(bus.err_illegal), 32'd1);
        check("ill_level", 32'(bus.fifo_level), 32'd1);
        @(negedge clk);
        check("ill_err_lo", 32'(bus.err_illegal), 32'd0);
`ifdef INSTR_ENC_STRICT_EN
        @(posedge clk); #1;
        r = zero_req();
        r.fmt = 0; r.op = 7'h30;
        send(r);
        @(negedge clk);
        check("strict_err_hi", 32'(bus.err_illegal), 32'd1);
        check("strict_level", 32'(bus.fifo_level), 32'd1);
        @(negedge clk);
        check("strict_err_lo", 32'(bus.err_illegal), 32'd0);
`endif
        @(posedge clk); #1;
        drain();

        // Reset in the middle of a long expansion
        bus.out_ready = 1'b0;
        r = zero_req();
        r.fmt = 5; r.op = 7'h0B; r.rstart = 4; r.rep = 10;
        send(r);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_level", 32'(bus.fifo_level), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Randomized traffic with random consumer stalls
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send(rand_req());
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();
        @(negedge clk);
        check("final_empty", 32'(bus.out_valid), 32'd0);
        check("final_level", 32'(bus.fifo_level), 32'd0);
        check("final_model_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end
endmodule
